csr_file: RTL and testbench
===========================

# csr_file

Machine-mode control and status register file for the RV32I core, the responder for CSR accesses issued by the instruction decoder. It serves combinational reads, registers writes at the clock edge, and maintains the 64-bit cycle and instret counters. It also keeps the trap state (mstatus/mepc/mcause/mtval) updated on trap entry and mret. The block sits beside the register file, with its address, write-enable and write-data inputs driven directly by the decoder's CSR outputs.

## Interface
- HART_ID, 0: value returned by mhartid (0xF14).
- MISA_VALUE, 32'h4000_0100: value returned by misa (RV32I), read-only.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- csr_en  in  1  current instruction is a CSR op; qualifies csr_we and csr_illegal.
- csr_addr  in  12  CSR address.
- csr_we  in  1  write strobe; effective only with csr_en.
- csr_wd  in  32  write data (already merged by decoder for set/clear forms).
- csr_rd  out  32  read data, combinational from current state.
- csr_illegal  out  1  csr_en high and address unimplemented; combinational.
- instret  in  1  an instruction retires this cycle.
- trap_valid  in  1  trap entry this cycle.
- trap_pc  in  32  pc of trapping instruction.
- trap_cause  in  32  mcause value.
- trap_tval  in  32  mtval value.
- mret  in  1  mret executes this cycle.
- trap_vector  out  32  current mtvec.
- epc  out  32  current mepc.
- irq_enable  out  1  mstatus.MIE.

## Operation
- Implemented: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82, mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14.
- Unimplemented address: csr_rd = 0, csr_illegal = csr_en, no state change.
- Read-only (misa, mip, 0xC**, 0xF**): writes silently ignored, not illegal. The decoder asserts csr_we for every CSR op, including csrrs x0.
- mip reads 0.
- mvendorid, marchid and mimpid read 0.
- mstatus: only MIE (bit 3) and MPIE (bit 7) are writable. MPP [12:11] reads constant 2'b11; all other bits read 0.
- mie: bits 3, 7 and 11 are writable; all others read 0.
- mtvec: bits [1:0] forced to 0 on write (direct mode only).
- mepc: bits [1:0] forced to 0 on write and on trap capture.
- mcycle: 64-bit, increments every cycle.
- minstret: 64-bit, increments when instret is high.
- Low-word wrap 0xFFFF_FFFF -> 0 carries into the high word.
- Counter write to the low or high word replaces that word only. The whole counter does not increment in the write cycle.
- Trap entry (trap_valid):
  - mepc <= trap_pc & ~3, mcause <= trap_cause, mtval <= trap_tval.
  - MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Precedence: reset > trap_valid > mret > CSR write.
  - A CSR write in a trap or mret cycle is dropped entirely.
  - Counters still increment in a trap or mret cycle.

## Timing
- Reads: zero latency. csr_rd reflects state before the edge, so csrrw returns the old value.
- Writes and counter updates become visible the cycle after.
- Reset values:
  - mstatus = 0x0000_1800.
  - mie, mtvec, mscratch, mepc, mcause, mtval = 0.
  - mcycle = minstret = 0.
  - trap_vector = 0, epc = 0, irq_enable = 0.
- mcycle reads 1 in the first cycle after reset deasserts.
- Reset asserted mid-trap or mid-write wins: all state returns to reset values on that edge.

## Structure
- Package csr_pkg holds:
  - CSR address localparams.
  - mstatus bit positions (MIE, MPIE, MPP).
  - Writable masks for mstatus and mie.
  - Reset value constants.
- Sub-module csr_counter64, instantiated twice (cycle, instret). Ports:
  - clk, reset, inc.
  - we_lo, we_hi, wd.
  - value[63:0].
- Its write-suppresses-increment and carry rules are as above.

## Test plan
- Reset, then idle 5 cycles -> mstatus reads 0x1800, misa reads 0x4000_0100, mcycle reads 5, minstret reads 0.
- csrrw mscratch with 0xDEAD_BEEF -> csr_rd returns 0 in that cycle; the next read returns 0xDEAD_BEEF. A write of 0x1003 to mtvec then reads back 0x1000.
- Write mcycle = 0xFFFF_FFFE, mcycleh = 0 -> after 2 cycles mcycleh = 1 and mcycle = 0. Write to cycle (0xC00) -> ignored, csr_illegal low.
- MIE = 1, then trap_valid with pc 0x0000_0102, cause 11 -> mepc = 0x100, mcause = 11, MIE = 0, MPIE = 1. Then mret -> MIE = 1, MPIE = 1.
- trap_valid and a mscratch write in the same cycle -> mscratch unchanged. A simultaneous instret -> minstret still increments.
- csr_en with address 0x7C0 -> csr_illegal = 1, csr_rd = 0, no state change. The same address with csr_en low -> csr_illegal = 0.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, mstatus layout, write masks and reset values
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP  = 11;

   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
   localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
   localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

   localparam logic [31:0] MSTATUS_RESET = MSTATUS_FIXED;
   localparam logic [31:0] CSR_RESET     = 32'h0000_0000;
   localparam logic [31:0] MISA_RV32I    = 32'h4000_0100;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with per-word write; a write cycle suppresses the increment
module csr_counter64
   import csr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wd,
   output logic [63:0] value
);

   always_ff @(posedge clk) begin
      if (reset) begin
         value <= 64'd0;
      end else if (we_lo || we_hi) begin
         if (we_lo) value[31:0]  <= wd;
         if (we_hi) value[63:32] <= wd;
      end else if (inc) begin
         value <= value + 64'd1;
      end
   end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap state and cycle/instret counters
module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] HART_ID    = 32'd0,
   parameter logic [31:0] MISA_VALUE = MISA_RV32I
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_en,
   input  logic [11:0] csr_addr,
   input  logic        csr_we,
   input  logic [31:0] csr_wd,
   output logic [31:0] csr_rd,
   output logic        csr_illegal,
   input  logic        instret,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret,
   output logic [31:0] trap_vector,
   output logic [31:0] epc,
   output logic        irq_enable
);

   logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [63:0] cycle_q, instret_q;
   logic        csr_wr, hit;
   logic [31:0] rd_data;

   // trap and mret take the whole cycle; a concurrent CSR write is dropped
   assign csr_wr = csr_en && csr_we && !trap_valid && !mret;

   csr_counter64 u_cycle (
      .clk   (clk),
      .reset (reset),
      .inc   (1'b1),
      .we_lo (csr_wr && (csr_addr == CSR_MCYCLE)),
      .we_hi (csr_wr && (csr_addr == CSR_MCYCLEH)),
      .wd    (csr_wd),
      .value (cycle_q)
   );

   csr_counter64 u_instret (
      .clk   (clk),
      .reset (reset),
      .inc   (instret),
      .we_lo (csr_wr && (csr_addr == CSR_MINSTRET)),
      .we_hi (csr_wr && (csr_addr == CSR_MINSTRETH)),
      .wd    (csr_wd),
      .value (instret_q)
   );

   always_comb begin
      rd_data = '0;
      hit     = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:                  rd_data = mstatus_q;
         CSR_MISA:                     rd_data = MISA_VALUE;
         CSR_MIE:                      rd_data = mie_q;
         CSR_MTVEC:                    rd_data = mtvec_q;
         CSR_MSCRATCH:                 rd_data = mscratch_q;
         CSR_MEPC:                     rd_data = mepc_q;
         CSR_MCAUSE:                   rd_data = mcause_q;
         CSR_MTVAL:                    rd_data = mtval_q;
         CSR_MCYCLE, CSR_CYCLE:        rd_data = cycle_q[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:      rd_data = cycle_q[63:32];
         CSR_MINSTRET, CSR_INSTRET:    rd_data = instret_q[31:0];
         CSR_MINSTRETH, CSR_INSTRETH:  rd_data = instret_q[63:32];
         CSR_MHARTID:                  rd_data = HART_ID;
         CSR_MIP, CSR_MVENDORID,
         CSR_MARCHID, CSR_MIMPID:      rd_data = '0;
         default:                      hit = 1'b0;
      endcase
   end

   assign csr_rd      = rd_data;
   assign csr_illegal = csr_en && !hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         mstatus_q  <= MSTATUS_RESET;
         mie_q      <= CSR_RESET;
         mtvec_q    <= CSR_RESET;
         mscratch_q <= CSR_RESET;
         mepc_q     <= CSR_RESET;
         mcause_q   <= CSR_RESET;
         mtval_q    <= CSR_RESET;
      end else if (trap_valid) begin
         mepc_q                  <= trap_pc & ALIGN4_MASK;
         mcause_q                <= trap_cause;
         mtval_q                 <= trap_tval;
         mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
         mstatus_q[MSTATUS_MIE]  <= 1'b0;
      end else if (mret) begin
         mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
         mstatus_q[MSTATUS_MPIE] <= 1'b1;
      end else if (csr_wr) begin
         // read-only and counter addresses fall through to default here
         case (csr_addr)
            CSR_MSTATUS:  mstatus_q  <= (csr_wd & MSTATUS_WMASK) | MSTATUS_FIXED;
            CSR_MIE:      mie_q      <= csr_wd & MIE_WMASK;
            CSR_MTVEC:    mtvec_q    <= csr_wd & ALIGN4_MASK;
            CSR_MSCRATCH: mscratch_q <= csr_wd;
            CSR_MEPC:     mepc_q     <= csr_wd & ALIGN4_MASK;
            CSR_MCAUSE:   mcause_q   <= csr_wd;
            CSR_MTVAL:    mtval_q    <= csr_wd;
            default:      ;
         endcase
      end
   end

   assign trap_vector = mtvec_q;
   assign epc         = mepc_q;
   assign irq_enable  = mstatus_q[MSTATUS_MIE];

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed table and sequence checks for csr_file
module tb_csr_file;

   logic        clk = 1'b0;
   logic        reset;
   logic        csr_en, csr_we, csr_illegal;
   logic [11:0] csr_addr;
   logic [31:0] csr_wd, csr_rd;
   logic        instret, trap_valid, mret, irq_enable;
   logic [31:0] trap_pc, trap_cause, trap_tval, trap_vector, epc;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [11:0] addr;
      logic        en;
      logic        we;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   vec_t vt[35];

   csr_file dut (
      .clk         (clk),
      .reset       (reset),
      .csr_en      (csr_en),
      .csr_addr    (csr_addr),
      .csr_we      (csr_we),
      .csr_wd      (csr_wd),
      .csr_rd      (csr_rd),
      .csr_illegal (csr_illegal),
      .instret     (instret),
      .trap_valid  (trap_valid),
      .trap_pc     (trap_pc),
      .trap_cause  (trap_cause),
      .trap_tval   (trap_tval),
      .mret        (mret),
      .trap_vector (trap_vector),
      .epc         (epc),
      .irq_enable  (irq_enable)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // apply one cycle of CSR inputs at the falling edge; sideband strobes default low
   task automatic drive(input logic [11:0] a, input logic en, input logic we, input logic [31:0] wd);
      @(negedge clk);
      csr_addr   = a;
      csr_en     = en;
      csr_we     = we;
      csr_wd     = wd;
      instret    = 1'b0;
      trap_valid = 1'b0;
      mret       = 1'b0;
      #1;
   endtask

   task automatic rd(input logic [11:0] a, input string name, input logic [31:0] exp);
      drive(a, 1'b1, 1'b0, 32'd0);
      check(name, csr_rd, exp);
   endtask

   initial begin
      vt[0]  = '{12'h300, 1'b1, 1'b0, 32'h0,        32'h0000_1800, 1'b0};
      vt[1]  = '{12'h301, 1'b1, 1'b0, 32'h0,        32'h4000_0100, 1'b0};
      vt[2]  = '{12'hB02, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0};
      vt[3]  = '{12'hF14, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0};
      vt[4]  = '{12'hB00, 1'b1, 1'b0, 32'h0,        32'd5,         1'b0};
      vt[5]  = '{12'hB80, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0};
      vt[6]  = '{12'hF11, 1'b1, 1'b1, 32'hFFFF,     32'h0,         1'b0};
      vt[7]  = '{12'h340, 1'b1, 1'b1, 32'hDEAD_BEEF,32'h0,         1'b0};
      vt[8]  = '{12'h340, 1'b1, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0};
      vt[9]  = '{12'h305, 1'b1, 1'b1, 32'h1003,     32'h0,         1'b0};
      vt[10] = '{12'h305, 1'b1, 1'b0, 32'h0,        32'h1000,      1'b0};
      vt[11] = '{12'h344, 1'b1, 1'b1, 32'hFFFF_FFFF,32'h0,         1'b0};
      vt[12] = '{12'h344, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0};
      vt[13] = '{12'h7C0, 1'b1, 1'b1, 32'h123,      32'h0,         1'b1};
      vt[14] = '{12'h7C0, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0};
      vt[15] = '{12'h300, 1'b1, 1'b1, 32'hFFFF_FFFF,32'h0000_1800, 1'b0};
      vt[16] = '{12'h300, 1'b1, 1'b0, 32'h0,        32'h0000_1888, 1'b0};
      vt[17] = '{12'h300, 1'b1, 1'b1, 32'h0,        32'h0000_1888, 1'b0};
      vt[18] = '{12'h300, 1'b1, 1'b0, 32'h0,        32'h0000_1800, 1'b0};
      vt[19] = '{12'h304, 1'b1, 1'b1, 32'hFFFF_FFFF,32'h0,         1'b0};
      vt[20] = '{12'h304, 1'b1, 1'b0, 32'h0,        32'h0000_0888, 1'b0};
      vt[21] = '{12'hB00, 1'b1, 1'b1, 32'hFFFF_FFFE,32'd22,        1'b0};
      vt[22] = '{12'hB80, 1'b1, 1'b1, 32'h0,        32'h0,         1'b0};
      vt[23] = '{12'hB00, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFE, 1'b0};
      vt[24] = '{12'hB00, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b0};
      vt[25] = '{12'hB00, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0};
      vt[26] = '{12'hB80, 1'b1, 1'b0, 32'h0,        32'h1,         1'b0};
      vt[27] = '{12'hC00, 1'b1, 1'b1, 32'h5,        32'h2,         1'b0};
      vt[28] = '{12'hB00, 1'b1, 1'b0, 32'h0,        32'h3,         1'b0};
      vt[29] = '{12'hB02, 1'b1, 1'b1, 32'h10,       32'h0,         1'b0};
      vt[30] = '{12'hB02, 1'b1, 1'b0, 32'h0,        32'h10,        1'b0};
      vt[31] = '{12'h341, 1'b1, 1'b1, 32'h107,      32'h0,         1'b0};
      vt[32] = '{12'h341, 1'b1, 1'b0, 32'h0,        32'h104,       1'b0};
      vt[33] = '{12'hC82, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0};
      vt[34] = '{12'h340, 1'b1, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0};

      reset = 1'b1;
      csr_en = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wd = 32'h0;
      instret = 1'b0; trap_valid = 1'b0; mret = 1'b0;
      trap_pc = 32'h0; trap_cause = 32'h0; trap_tval = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      csr_en = 1'b1; csr_addr = 12'h300;
      #1;
      check("reset_mstatus", csr_rd, 32'h0000_1800);
      check("reset_trap_vector", trap_vector, 32'h0);
      check("reset_epc", epc, 32'h0);
      check("reset_irq_enable", {31'd0, irq_enable}, 32'h0);
      csr_addr = 12'hB00;
      #1;
      check("reset_mcycle", csr_rd, 32'h0);

      for (int i = 0; i < 35; i++) begin
         drive(vt[i].addr, vt[i].en, vt[i].we, vt[i].wd);
         check($sformatf("vec%0d_rd", i), csr_rd, vt[i].exp_rd);
         check($sformatf("vec%0d_illegal", i), {31'd0, csr_illegal}, {31'd0, vt[i].exp_ill});
      end

      // trap entry with a concurrent mscratch write and retiring instruction
      drive(12'h300, 1'b1, 1'b1, 32'h8);
      drive(12'h340, 1'b1, 1'b1, 32'h1234_5678);
      trap_valid = 1'b1; trap_pc = 32'h0000_0102; trap_cause = 32'd11;
      trap_tval = 32'h55; instret = 1'b1;
      check("pre_trap_irq_enable", {31'd0, irq_enable}, 32'h1);
      check("trap_cycle_rd_old", csr_rd, 32'hDEAD_BEEF);
      rd(12'h341, "trap_mepc", 32'h100);
      check("trap_epc_out", epc, 32'h100);
      check("trap_irq_enable", {31'd0, irq_enable}, 32'h0);
      rd(12'h342, "trap_mcause", 32'd11);
      rd(12'h343, "trap_mtval", 32'h55);
      rd(12'h300, "trap_mstatus", 32'h0000_1880);
      rd(12'h340, "trap_mscratch_kept", 32'hDEAD_BEEF);
      rd(12'hB02, "trap_minstret_inc", 32'h11);

      // mret restores MIE from MPIE and drops the concurrent write
      drive(12'h340, 1'b1, 1'b1, 32'h1);
      mret = 1'b1;
      rd(12'h300, "mret_mstatus", 32'h0000_1888);
      check("mret_irq_enable", {31'd0, irq_enable}, 32'h1);
      rd(12'h340, "mret_mscratch_kept", 32'hDEAD_BEEF);

      // mret with MPIE clear leaves MIE clear and sets MPIE
      drive(12'h300, 1'b1, 1'b1, 32'h0);
      drive(12'h300, 1'b1, 1'b0, 32'h0);
      mret = 1'b1;
      check("pre_mret2_mstatus", csr_rd, 32'h0000_1800);
      rd(12'h300, "mret2_mstatus", 32'h0000_1880);
      check("trap_vector_out", trap_vector, 32'h1000);

      // reset asserted together with a trap and a write
      drive(12'h340, 1'b1, 1'b1, 32'hAAAA_0000);
      drive(12'h340, 1'b1, 1'b1, 32'hBBBB_0000);
      trap_valid = 1'b1; reset = 1'b1;
      rd(12'h300, "rst_mstatus", 32'h0000_1800);
      check("rst_epc", epc, 32'h0);
      check("rst_trap_vector", trap_vector, 32'h0);
      check("rst_irq_enable", {31'd0, irq_enable}, 32'h0);
      rd(12'h340, "rst_mscratch", 32'h0);
      rd(12'hB00, "rst_mcycle", 32'h0);
      reset = 1'b0;
      rd(12'hB00, "post_rst_mcycle", 32'h1);
      rd(12'hB02, "post_rst_minstret", 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
